msp430_ram_arb: RTL and testbench
=================================

Name: msp430_ram_arb

Overview:
Two-master arbiter directly upstream of the scalable RAM model. It drives the RAM's ram_addr/ram_cen/ram_din/ram_wen and returns ram_dout to the winning master. Port 0 is the CPU memory backbone and port 1 is a DMA/debug master. Fixed priority goes to port 0, bounded by a starvation counter so port 1 always makes progress.

Parameters:
ADDR_MSB, 6, MSB of word address bus (matches RAM)
MEM_SIZE, 256, RAM size in bytes; valid word addresses 0..MEM_SIZE/2-1
STARVE_MAX, 4, max consecutive port-0 grants while port 1 waits (1..15)

Ports:
mclk  in  1  clock, shared with RAM ram_clk
puc_rst  in  1  synchronous active-high reset
p0_req  in  1  port 0 access request
p0_addr  in  ADDR_MSB+1  port 0 word address
p0_din  in  16  port 0 write data
p0_wen  in  2  port 0 byte write enable, low active; 2'b11 = read
p0_gnt  out  1  port 0 granted this cycle (combinational)
p0_rdy  out  1  port 0 read data valid on p0_dout (registered)
p0_dout  out  16  port 0 read data
p1_req, p1_addr, p1_din, p1_wen, p1_gnt, p1_rdy, p1_dout: same as port 0 for port 1
ram_addr  out  ADDR_MSB+1  to RAM
ram_cen  out  1  to RAM, low active
ram_din  out  16  to RAM
ram_wen  out  2  to RAM, low active
ram_dout  in  16  from RAM
rng_err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (puc_rst=1 at posedge): starve_cnt=0, p0_rdy=p1_rdy=0, rng_err=0. While puc_rst=1, p0_gnt=p1_gnt=0 and ram_cen=1 combinationally.
- Arbitration is combinational, one access per cycle:
  - Only one port requesting: that port wins.
  - Both requesting: port 1 wins if starve_cnt==STARVE_MAX, else port 0.
- Winner's addr/din/wen are muxed to the RAM and ram_cen=0. No requests: ram_cen=1, ram_wen=2'b11, addr/din hold the port 0 values.
- A master holds req/addr/din/wen stable until it sees gnt=1 on a clock edge. A gnt cycle completes the access; there are no wait states after grant.
- starve_cnt:
  - +1 on each edge where p0 is granted while p1_req=1, saturating at STARVE_MAX.
  - Cleared on any edge where p1 is granted or p1_req=0.
- Read latency 1: on the edge of a read grant (wen==2'b11), pX_rdy<=1 for the granted port, else 0. pX_rdy is a single-cycle pulse per read.
- pX_dout = ram_dout for both ports. Data is valid only while pX_rdy=1.
- Writes (wen!=2'b11) produce no rdy.
- Back-to-back reads from the same port give rdy high on consecutive cycles. A read granted on port 1 directly after a port 0 read gives p0_rdy then p1_rdy on adjacent cycles, never both at once.
- Reset asserted one cycle after a read grant: rdy is cleared at that edge and the read is lost. The master must reissue it.
- wen=2'b00 gives a 16-bit write. 2'b01 writes the upper byte and 2'b10 the lower byte; both pass straight through.

Optional Feature:
Macro RAM_ARB_RANGE_CHK_EN.
- Defined: a granted access with addr >= MEM_SIZE/2 is still granted (master is not stalled), but ram_cen stays 1. A read returns pX_rdy=1 with pX_dout=16'h0000. rng_err<=1 and stays set until puc_rst.
- Undefined: out-of-range addresses pass through to the RAM unchanged (the RAM ignores them). rng_err is tied to 0.

Test Plan:
- Reset: puc_rst=1 with p0_req=p1_req=1 -> gnt=0, ram_cen=1, rdy=0. Release, then p0 read addr 5 -> p0_gnt same cycle, p0_rdy next cycle with RAM word 5.
- Write/readback: p1 writes 16'hA55A to addr 3 (wen=00), then wen=10 with din=16'h00FF -> a read of addr 3 returns 16'hA5FF one cycle after grant.
- Contention, STARVE_MAX=4: both requesting continuously -> grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1. starve_cnt clears after each p1 grant.
- Alternating reads: p0 read addr 1 at cycle n, p1 read addr 2 at cycle n+1 -> p0_rdy at n+1 and p1_rdy at n+2 with correct words; never overlapping.
- Reset mid-read: p0 read granted at cycle n, puc_rst=1 at cycle n+1 -> p0_rdy=0 at n+1 and starve_cnt=0.
- RAM_ARB_RANGE_CHK_EN, MEM_SIZE=256: p0 read addr 7'h7F (127, in range) -> normal data. With ADDR_MSB=7, addr 8'h80 -> ram_cen=1, p0_rdy=1, p0_dout=0, rng_err=1 until reset. Without the macro, rng_err stays 0.

Source files
------------

// File: rtl/msp430_ram_arb.sv
//==============================================================================
// Module   : msp430_ram_arb
// Brief    : Two-master fixed-priority RAM arbiter with starvation bound;
//            optional out-of-range check enabled by RAM_ARB_RANGE_CHK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module msp430_ram_arb #(
    parameter int ADDR_MSB   = 6,
    parameter int MEM_SIZE   = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic                mclk,
    input  logic                puc_rst,
    // port 0 : CPU memory backbone
    input  logic                p0_req,
    input  logic [ADDR_MSB:0]   p0_addr,
    input  logic [15:0]         p0_din,
    input  logic [1:0]          p0_wen,
    output logic                p0_gnt,
    output logic                p0_rdy,
    output logic [15:0]         p0_dout,
    // port 1 : DMA / debug master
    input  logic                p1_req,
    input  logic [ADDR_MSB:0]   p1_addr,
    input  logic [15:0]         p1_din,
    input  logic [1:0]          p1_wen,
    output logic                p1_gnt,
    output logic                p1_rdy,
    output logic [15:0]         p1_dout,
    // RAM side
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [15:0]         ram_din,
    output logic [1:0]          ram_wen,
    input  logic [15:0]         ram_dout,
    output logic                rng_err
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || MEM_SIZE < 2) begin : g_bad_cfg
        $error("msp430_ram_arb: unsupported parameter set");
    end

    logic [3:0]         r_starve_cnt;
    logic               r_p0_rdy;
    logic               r_p1_rdy;
    logic               w_p1_win;
    logic               w_p0_gnt;
    logic               w_p1_gnt;
    logic               w_any_gnt;
    logic               w_is_read;
    logic               w_oor;
    logic [ADDR_MSB:0]  w_addr;
    logic [15:0]        w_din;
    logic [1:0]         w_wen;

    // Port 0 wins ties unless port 1 has waited STARVE_MAX consecutive grants.
    always_comb begin
        w_p1_win  = p1_req & (~p0_req | (r_starve_cnt == c_starve_max));
        w_p1_gnt  = ~puc_rst & w_p1_win;
        w_p0_gnt  = ~puc_rst & p0_req & ~w_p1_win;
        w_any_gnt = w_p0_gnt | w_p1_gnt;
        w_addr    = w_p1_gnt ? p1_addr : p0_addr;
        w_din     = w_p1_gnt ? p1_din  : p0_din;
        w_wen     = w_p1_gnt ? p1_wen  : (w_p0_gnt ? p0_wen : 2'b11);
        w_is_read = w_any_gnt & (w_wen == 2'b11);
    end

`ifdef RAM_ARB_RANGE_CHK_EN
    localparam logic [31:0] c_mem_words = 32'(MEM_SIZE / 2);

    logic r_rd_zero;
    logic r_rng_err;

    assign w_oor = w_any_gnt & (32'(w_addr) >= c_mem_words);

    // Out-of-range reads still complete, but return zero instead of RAM data.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_rd_zero <= 1'b0;
            r_rng_err <= 1'b0;
        end else begin
            r_rd_zero <= w_is_read & w_oor;
            r_rng_err <= r_rng_err | w_oor;
        end
    end

    assign p0_dout = r_rd_zero ? 16'h0000 : ram_dout;
    assign p1_dout = r_rd_zero ? 16'h0000 : ram_dout;
    assign rng_err = r_rng_err;
`else
    assign w_oor   = 1'b0;
    assign p0_dout = ram_dout;
    assign p1_dout = ram_dout;
    assign rng_err = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_starve_cnt <= 4'd0;
            r_p0_rdy     <= 1'b0;
            r_p1_rdy     <= 1'b0;
        end else begin
            if (w_p1_gnt || !p1_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_p0_gnt && (r_starve_cnt != c_starve_max)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            r_p0_rdy <= w_p0_gnt & w_is_read;
            r_p1_rdy <= w_p1_gnt & w_is_read;
        end
    end

    assign p0_gnt   = w_p0_gnt;
    assign p1_gnt   = w_p1_gnt;
    assign ram_addr = w_addr;
    assign ram_din  = w_din;
    assign ram_wen  = w_wen;
    assign ram_cen  = ~(w_any_gnt & ~w_oor);

    // A read pending when reset arrives is dropped immediately, not delivered.
    assign p0_rdy   = r_p0_rdy & ~puc_rst;
    assign p1_rdy   = r_p1_rdy & ~puc_rst;

endmodule

`default_nettype wire

// File: tb/tb_msp430_ram_arb.sv
//==============================================================================
// Module   : tb_msp430_ram_arb
// Brief    : Scoreboard bench for msp430_ram_arb with a behavioural RAM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_msp430_ram_arb;

    localparam int ADDR_MSB   = 7;
    localparam int MEM_SIZE   = 256;
    localparam int STARVE_MAX = 4;
    localparam int WORDS      = MEM_SIZE / 2;
`ifdef RAM_ARB_RANGE_CHK_EN
    localparam logic [15:0] OOR_WORD = 16'h0000;
    localparam logic        OOR_CEN  = 1'b1;
    localparam logic        EXP_RNG  = 1'b1;
`else
    localparam logic [15:0] OOR_WORD = 16'hDEAD;
    localparam logic        OOR_CEN  = 1'b0;
    localparam logic        EXP_RNG  = 1'b0;
`endif

    logic                mclk = 1'b0;
    logic                puc_rst;
    logic                p0_req, p1_req, p0_gnt, p1_gnt, p0_rdy, p1_rdy;
    logic [ADDR_MSB:0]   p0_addr, p1_addr, ram_addr;
    logic [15:0]         p0_din, p1_din, p0_dout, p1_dout, ram_din, ram_dout;
    logic [1:0]          p0_wen, p1_wen, ram_wen;
    logic                ram_cen, rng_err;

    int tests = 0;
    int fails = 0;

    logic [15:0] shadow [WORDS];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    always #5 mclk = ~mclk;

    msp430_ram_arb #(
        .ADDR_MSB   (ADDR_MSB),
        .MEM_SIZE   (MEM_SIZE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .p0_req   (p0_req),
        .p0_addr  (p0_addr),
        .p0_din   (p0_din),
        .p0_wen   (p0_wen),
        .p0_gnt   (p0_gnt),
        .p0_rdy   (p0_rdy),
        .p0_dout  (p0_dout),
        .p1_req   (p1_req),
        .p1_addr  (p1_addr),
        .p1_din   (p1_din),
        .p1_wen   (p1_wen),
        .p1_gnt   (p1_gnt),
        .p1_rdy   (p1_rdy),
        .p1_dout  (p1_dout),
        .ram_addr (ram_addr),
        .ram_cen  (ram_cen),
        .ram_din  (ram_din),
        .ram_wen  (ram_wen),
        .ram_dout (ram_dout),
        .rng_err  (rng_err)
    );

    function automatic logic [15:0] init_word(input int i);
        return {i[7:0], ~i[7:0]};
    endfunction

    // Behavioural RAM: one-cycle read latency, per-byte low-active write enables.
    logic [15:0] ram_mem [WORDS];
    logic [15:0] ram_q;
    logic        ram_init;
    assign ram_dout = ram_q;

    always @(posedge mclk) begin
        if (ram_init) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
            ram_q <= 16'h0000;
        end else if (!ram_cen) begin
            if (int'(ram_addr) < WORDS) begin
                if (ram_wen == 2'b11) ram_q <= ram_mem[ram_addr[6:0]];
                if (!ram_wen[1]) ram_mem[ram_addr[6:0]][15:8] <= ram_din[15:8];
                if (!ram_wen[0]) ram_mem[ram_addr[6:0]][7:0]  <= ram_din[7:0];
            end else begin
                ram_q <= 16'hDEAD;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard entry for a granted access, taken from the bench's own drive values.
    task automatic record(input int port);
        logic [ADDR_MSB:0] a;
        logic [15:0]       d;
        logic [1:0]        w;
        logic [15:0]       e;
        a = (port == 0) ? p0_addr : p1_addr;
        d = (port == 0) ? p0_din  : p1_din;
        w = (port == 0) ? p0_wen  : p1_wen;
        if (w == 2'b11) begin
            e = (int'(a) >= WORDS) ? OOR_WORD : shadow[a[6:0]];
            if (port == 0) q0.push_back(e);
            else           q1.push_back(e);
        end else if (int'(a) < WORDS) begin
            if (!w[1]) shadow[a[6:0]][15:8] = d[15:8];
            if (!w[0]) shadow[a[6:0]][7:0]  = d[7:0];
        end
    endtask

    always @(negedge mclk) begin
        if (p0_rdy) begin
            chk("p0_rdy_expected", 32'(p0_rdy), 32'(q0.size() != 0));
            if (q0.size() != 0) chk("p0_dout", 32'(p0_dout), 32'(q0.pop_front()));
        end
        if (p1_rdy) begin
            chk("p1_rdy_expected", 32'(p1_rdy), 32'(q1.size() != 0));
            if (q1.size() != 0) chk("p1_dout", 32'(p1_dout), 32'(q1.pop_front()));
        end
        if (p0_rdy || p1_rdy) chk("rdy_overlap", 32'(p0_rdy & p1_rdy), 32'd0);
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic [ADDR_MSB:0] a,
                          input logic [15:0] d, input logic [1:0] w);
        p0_req = r; p0_addr = a; p0_din = d; p0_wen = w;
    endtask

    task automatic set_p1(input logic r, input logic [ADDR_MSB:0] a,
                          input logic [15:0] d, input logic [1:0] w);
        p1_req = r; p1_addr = a; p1_din = d; p1_wen = w;
    endtask

    // Present a request and hold it until granted (bounded), then release it.
    task automatic issue(input int port, input logic [ADDR_MSB:0] a,
                         input logic [15:0] d, input logic [1:0] w, input string tag);
        logic g;
        g = 1'b0;
        if (port == 0) set_p0(1'b1, a, d, w);
        else           set_p1(1'b1, a, d, w);
        for (int k = 0; k < 20; k++) begin
            @(negedge mclk);
            g = (port == 0) ? p0_gnt : p1_gnt;
            if (g) break;
        end
        chk(tag, 32'(g), 32'd1);
        if (g) record(port);
        step();
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    // Both ports request every cycle; a counter model predicts each winner.
    task automatic contend(input int n, input string tag);
        int  cnt;
        logic exp_p1;
        cnt = 0;
        set_p0(1'b1, 8'd20, 16'h0, 2'b11);
        set_p1(1'b1, 8'd21, 16'h0, 2'b11);
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            exp_p1 = (cnt == STARVE_MAX);
            chk({tag, "_p1_gnt"}, 32'(p1_gnt), 32'(exp_p1));
            chk({tag, "_p0_gnt"}, 32'(p0_gnt), 32'(!exp_p1));
            if (p1_gnt)      record(1);
            else if (p0_gnt) record(0);
            cnt = exp_p1 ? 0 : cnt + 1;
            step();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
        ram_init = 1'b1;
        puc_rst  = 1'b1;
        set_p0(1'b1, 8'd5, 16'h0, 2'b11);
        set_p1(1'b1, 8'd6, 16'h0, 2'b11);

        // Reset holds both grants off even with requests pending.
        @(negedge mclk);
        chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        chk("rst_cen",    32'(ram_cen), 32'd1);
        chk("rst_p0_rdy", 32'(p0_rdy), 32'd0);
        chk("rst_p1_rdy", 32'(p1_rdy), 32'd0);
        chk("rst_rng",    32'(rng_err), 32'd0);
        step();
        puc_rst  = 1'b0;
        ram_init = 1'b0;
        p0_req   = 1'b0;
        p1_req   = 1'b0;
        step();

        // First read: grant in the same cycle, data one cycle later.
        set_p0(1'b1, 8'd5, 16'h0, 2'b11);
        @(negedge mclk);
        chk("rd5_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("rd5_cen",    32'(ram_cen), 32'd0);
        if (p0_gnt) record(0);
        step();
        p0_req = 1'b0;
        @(negedge mclk);
        chk("rd5_p0_rdy", 32'(p0_rdy), 32'd1);
        chk("rd5_dout",   32'(p0_dout), 32'h05FA);
        step();

        // Full write, lower-byte write, upper-byte write, with readbacks.
        issue(1, 8'd3, 16'hA55A, 2'b00, "wr_full_gnt");
        issue(1, 8'd3, 16'h00FF, 2'b10, "wr_lo_gnt");
        chk("wr_no_rdy", 32'(p1_rdy), 32'd0);
        issue(1, 8'd3, 16'h0000, 2'b11, "rb1_gnt");
        @(negedge mclk);
        chk("rb1_rdy",  32'(p1_rdy), 32'd1);
        chk("rb1_dout", 32'(p1_dout), 32'hA5FF);
        step();
        issue(1, 8'd3, 16'h3C00, 2'b01, "wr_hi_gnt");
        issue(1, 8'd3, 16'h0000, 2'b11, "rb2_gnt");
        @(negedge mclk);
        chk("rb2_dout", 32'(p1_dout), 32'h3CFF);
        step();

        contend(10, "cont");
        step();
        step();

        // Alternating ports: rdy pulses on adjacent cycles, never together.
        set_p0(1'b1, 8'd1, 16'h0, 2'b11);
        @(negedge mclk);
        chk("alt_p0_gnt", 32'(p0_gnt), 32'd1);
        if (p0_gnt) record(0);
        step();
        p0_req = 1'b0;
        set_p1(1'b1, 8'd2, 16'h0, 2'b11);
        @(negedge mclk);
        chk("alt_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("alt_p0_rdy", 32'(p0_rdy), 32'd1);
        chk("alt_p1_rdy_early", 32'(p1_rdy), 32'd0);
        if (p1_gnt) record(1);
        step();
        p1_req = 1'b0;
        @(negedge mclk);
        chk("alt_p1_rdy", 32'(p1_rdy), 32'd1);
        chk("alt_p0_rdy_late", 32'(p0_rdy), 32'd0);
        step();

        // Back-to-back reads on port 0.
        set_p0(1'b1, 8'd10, 16'h0, 2'b11);
        @(negedge mclk);
        chk("b2b_gnt0", 32'(p0_gnt), 32'd1);
        if (p0_gnt) record(0);
        step();
        p0_addr = 8'd11;
        @(negedge mclk);
        chk("b2b_gnt1", 32'(p0_gnt), 32'd1);
        chk("b2b_rdy0", 32'(p0_rdy), 32'd1);
        if (p0_gnt) record(0);
        step();
        p0_req = 1'b0;
        @(negedge mclk);
        chk("b2b_rdy1", 32'(p0_rdy), 32'd1);
        step();

        // Reset right after a read grant, with the starve counter part-way up.
        set_p0(1'b1, 8'd30, 16'h0, 2'b11);
        set_p1(1'b1, 8'd31, 16'h0, 2'b11);
        for (int k = 0; k < 2; k++) begin
            @(negedge mclk);
            chk("mid_p0_gnt", 32'(p0_gnt), 32'd1);
            if (p0_gnt) record(0);
            step();
        end
        puc_rst = 1'b1;
        @(negedge mclk);
        chk("mid_p0_rdy", 32'(p0_rdy), 32'd0);
        chk("mid_gnt",    32'({p0_gnt, p1_gnt}), 32'd0);
        chk("mid_cen",    32'(ram_cen), 32'd1);
        q0.delete();
        q1.delete();
        step();
        puc_rst = 1'b0;
        contend(6, "post_rst");
        step();
        step();

        // Range boundary: last valid word, then first word beyond the RAM.
        issue(0, 8'h7F, 16'h0000, 2'b11, "rng_in_gnt");
        @(negedge mclk);
        chk("rng_in_dout", 32'(p0_dout), 32'h7F80);
        chk("rng_in_err",  32'(rng_err), 32'd0);
        step();
        set_p0(1'b1, 8'h80, 16'h0, 2'b11);
        @(negedge mclk);
        chk("rng_out_gnt", 32'(p0_gnt), 32'd1);
        chk("rng_out_cen", 32'(ram_cen), 32'(OOR_CEN));
        if (p0_gnt) record(0);
        step();
        p0_req = 1'b0;
        @(negedge mclk);
        chk("rng_out_rdy",  32'(p0_rdy), 32'd1);
        chk("rng_out_dout", 32'(p0_dout), 32'(OOR_WORD));
        chk("rng_out_err",  32'(rng_err), 32'(EXP_RNG));
        step();
        issue(0, 8'd4, 16'h1234, 2'b00, "rng_after_gnt");
        chk("rng_sticky", 32'(rng_err), 32'(EXP_RNG));
        puc_rst = 1'b1;
        step();
        puc_rst = 1'b0;
        @(negedge mclk);
        chk("rng_cleared", 32'(rng_err), 32'd0);
        step();
        issue(0, 8'd4, 16'h0000, 2'b11, "rb4_gnt");
        step();
        step();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
